// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: instruction memory geometry, reset vector and FSM states.
package fetch_pkg;

  localparam int unsigned NUMBER_OF_INSTRUCTIONS = 1024;
  localparam int unsigned WORD_SIZE              = 32;
  localparam int unsigned IMEM_ADDR_BITS         = $clog2(NUMBER_OF_INSTRUCTIONS);
  localparam logic [WORD_SIZE-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage driving a one-cycle-latency synchronous instruction memory,
// with redirect, consumer stall and a hold register that keeps the output stable.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [WORD_SIZE-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic [WORD_SIZE-1:0] imem_addr,
  input  logic [WORD_SIZE-1:0] imem_instr,
  output logic [WORD_SIZE-1:0] instr_out,
  output logic [WORD_SIZE-1:0] pc_out,
  output logic                 instr_valid
);

  localparam int unsigned ADDR_PAD = WORD_SIZE - IMEM_ADDR_BITS;

  fetch_state_t         state_q, state_d;
  logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_SIZE-1:0] inflight_pc_q, inflight_pc_d;
  logic [WORD_SIZE-1:0] hold_q, hold_d;
  logic [WORD_SIZE-1:0] redirect_target;

  // Misaligned low bits of the redirect target are silently dropped.
  assign redirect_target = redirect_pc & ~WORD_SIZE'(3);

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    hold_d        = hold_q;
    case (state_q)
      EMPTY: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_target;
        end else begin
          inflight_pc_d = fetch_pc_q;
          fetch_pc_d    = fetch_pc_q + WORD_SIZE'(4);
          state_d       = RUN;
        end
      end
      RUN: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_target;
          state_d    = EMPTY;
        end else if (stall) begin
          // Memory output is only valid this cycle, so park it for the stall.
          hold_d  = imem_instr;
          state_d = HOLD;
        end else begin
          inflight_pc_d = fetch_pc_q;
          fetch_pc_d    = fetch_pc_q + WORD_SIZE'(4);
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_target;
          state_d    = EMPTY;
        end else if (!stall) begin
          inflight_pc_d = fetch_pc_q;
          fetch_pc_d    = fetch_pc_q + WORD_SIZE'(4);
          state_d       = RUN;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= EMPTY;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      hold_q        <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      hold_q        <= hold_d;
    end
  end

  // Outputs decode straight from registered state so reset clears them without a clock.
  always_comb begin
    instr_valid = 1'b0;
    instr_out   = '0;
    pc_out      = '0;
    case (state_q)
      RUN: begin
        instr_valid = 1'b1;
        instr_out   = imem_instr;
        pc_out      = inflight_pc_q;
      end
      HOLD: begin
        instr_valid = 1'b1;
        instr_out   = hold_q;
        pc_out      = inflight_pc_q;
      end
      default: begin
        instr_valid = 1'b0;
      end
    endcase
  end

  assign imem_addr = {ADDR_PAD'(0), fetch_pc_q[IMEM_ADDR_BITS+1:2]};

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized
// stall/redirect traffic compared every cycle against a stream-level reference model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr = 32'h0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [1024];

  // Reference model: whether a word is presented, its byte address, and the next address to fetch.
  logic        m_valid = 1'b0;
  logic [31:0] m_pc    = 32'h0;
  logic [31:0] m_fetch = 32'h0;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .instr_out     (instr_out),
    .pc_out        (pc_out),
    .instr_valid   (instr_valid)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i);
  end

  always @(posedge clk) imem_instr <= mem[imem_addr[9:0]];

  // Each accepted word advances the stream by 4; redirect squashes and restarts at the aligned target.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid <= 1'b0;
      m_pc    <= 32'h0;
      m_fetch <= 32'h0;
    end else if (redirect_valid) begin
      m_valid <= 1'b0;
      m_fetch <= redirect_pc & 32'hFFFF_FFFC;
    end else if (!m_valid || !stall) begin
      m_valid <= 1'b1;
      m_pc    <= m_fetch;
      m_fetch <= m_fetch + 32'd4;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cmp_valid", {31'b0, instr_valid}, {31'b0, m_valid});
    chk("cmp_instr", instr_out, m_valid ? (32'h1000_0000 + {22'b0, m_pc[11:2]}) : 32'h0);
    chk("cmp_pc", pc_out, m_valid ? m_pc : 32'h0);
    chk("cmp_imem_addr", imem_addr, {22'b0, m_fetch[11:2]});
  end

  task automatic drive(input logic s, input logic r, input logic [31:0] p);
    stall          = s;
    redirect_valid = r;
    redirect_pc    = p;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic v, input logic [31:0] pc,
                         input logic [31:0] ins);
    chk({name, "_valid"}, {31'b0, instr_valid}, {31'b0, v});
    chk({name, "_pc"}, pc_out, pc);
    chk({name, "_instr"}, instr_out, ins);
  endtask

  task automatic reset_release_seq(input string tag);
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    mid();
    chk({tag, "_first_valid"}, {31'b0, instr_valid}, 32'h0);
    chk({tag, "_first_addr"}, imem_addr, 32'h0);
    tick();
    mid(); chk_out({tag, "_w0"}, 1'b1, 32'h0, 32'h1000_0000); tick();
    mid(); chk_out({tag, "_w1"}, 1'b1, 32'h4, 32'h1000_0001); tick();
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_out("reset_state", 1'b0, 32'h0, 32'h0);
    chk("reset_addr", imem_addr, 32'h0);

    reset_release_seq("boot");

    // Stall three cycles on pc 8, then release.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0); mid(); chk_out("stall_hold", 1'b1, 32'h8, 32'h1000_0002); tick();
    end
    drive(1'b0, 1'b0, 32'h0); mid(); chk_out("stall_release", 1'b1, 32'h8, 32'h1000_0002); tick();
    drive(1'b0, 1'b1, 32'h0); mid(); chk_out("after_stall", 1'b1, 32'hC, 32'h1000_0003); tick();

    drive(1'b0, 1'b0, 32'h0); mid(); chk_out("redir0_bubble", 1'b0, 32'h0, 32'h0); tick();
    drive(1'b0, 1'b0, 32'h0); mid(); chk_out("redir0_w0", 1'b1, 32'h0, 32'h1000_0000); tick();
    drive(1'b0, 1'b1, 32'h40); mid(); chk_out("redir40_src", 1'b1, 32'h4, 32'h1000_0001); tick();
    drive(1'b0, 1'b0, 32'h0); mid(); chk_out("redir40_bubble", 1'b0, 32'h0, 32'h0); tick();
    drive(1'b1, 1'b0, 32'h0); mid(); chk_out("redir40_tgt", 1'b1, 32'h40, 32'h1000_0010); tick();

    // Redirect together with stall while holding: redirect wins, misaligned bits dropped.
    drive(1'b1, 1'b1, 32'h47); mid(); chk_out("hold_redir_src", 1'b1, 32'h40, 32'h1000_0010); tick();
    drive(1'b0, 1'b0, 32'h0); mid(); chk_out("hold_redir_bubble", 1'b0, 32'h0, 32'h0);
    chk("hold_redir_addr", imem_addr, 32'h11); tick();
    drive(1'b0, 1'b0, 32'h0); mid(); chk_out("hold_redir_tgt", 1'b1, 32'h44, 32'h1000_0011); tick();

    // Wrap of the word index at the top of the 4 KiB memory.
    drive(1'b0, 1'b1, 32'hFFC); mid(); chk_out("wrap_src", 1'b1, 32'h48, 32'h1000_0012); tick();
    drive(1'b0, 1'b0, 32'h0); mid(); chk("wrap_addr_top", imem_addr, 32'd1023); tick();
    drive(1'b0, 1'b0, 32'h0); mid(); chk_out("wrap_ffc", 1'b1, 32'hFFC, 32'h1000_03FF);
    chk("wrap_addr_zero", imem_addr, 32'h0); tick();
    drive(1'b0, 1'b0, 32'h0); mid(); chk_out("wrap_1000", 1'b1, 32'h1000, 32'h1000_0000);
    chk("wrap_addr_one", imem_addr, 32'h1); tick();

    // Asynchronous reset in the middle of a stall.
    drive(1'b1, 1'b0, 32'h0); mid(); tick();
    drive(1'b1, 1'b0, 32'h0); mid(); chk_out("pre_reset_hold", 1'b1, 32'h1004, 32'h1000_0001);
    #2 reset = 1'b0;
    #1;
    chk_out("async_reset", 1'b0, 32'h0, 32'h0);
    chk("async_reset_addr", imem_addr, 32'h0);
    tick();
    tick();
    reset_release_seq("rerun");

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 1500; i++) begin
      logic        s, r;
      logic [31:0] p;
      s = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 99) < 8);
      case ($urandom_range(0, 3))
        0:       p = $urandom;
        1:       p = 32'hFF0 + 32'($urandom_range(0, 15));
        2:       p = 32'($urandom_range(0, 255));
        default: p = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      endcase
      drive(s, r, p);
      tick();
    end

    drive(1'b0, 1'b0, 32'h0);
    mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 The block SHALL have port clk, input, 1, single clock; all state updates on posedge.
REQ-003 The block SHALL have port reset, input, 1, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port stall, input, 1, consumer not accepting instr_out this cycle.
REQ-005 The block SHALL have port redirect_valid, input, 1, load new PC this cycle.
REQ-006 The block SHALL have port redirect_pc, input, 32, redirect byte address.
REQ-007 The block SHALL have port imem_addr, output, 32, word index driven to the 1024-word synchronous instruction memory.
REQ-008 The block SHALL have port imem_instr, input, 32, memory data for the address presented on the previous cycle.
REQ-009 The block SHALL have port instr_out, output, 32, fetched instruction.
REQ-010 The block SHALL have port pc_out, output, 32, byte address of instr_out.
REQ-011 The block SHALL have port instr_valid, output, 1, instr_out/pc_out valid.

Function
REQ-012 Registers SHALL be fetch_pc (next address to issue), inflight_pc (address of the word now on imem_instr), hold_reg (32), and state in {EMPTY, RUN, HOLD}.
REQ-013 imem_addr SHALL equal {22'b0, fetch_pc[11:2]}, so it wraps modulo 4 KiB; fetch_pc itself SHALL wrap modulo 2^32.
REQ-014 A redirect SHALL load fetch_pc with {redirect_pc[31:2], 2'b00}, silently dropping misaligned bits.
REQ-015 An issue SHALL perform inflight_pc <= fetch_pc and fetch_pc <= fetch_pc + 4.
REQ-016 In EMPTY: instr_valid=0, instr_out=0, pc_out=0; on redirect load fetch_pc and stay EMPTY; otherwise issue and go to RUN; stall SHALL be ignored.
REQ-017 In RUN: instr_valid=1, instr_out=imem_instr, pc_out=inflight_pc; on redirect load fetch_pc and go to EMPTY; otherwise on stall capture hold_reg <= imem_instr, leave fetch_pc unchanged and go to HOLD; otherwise issue and stay in RUN.
REQ-018 In HOLD: instr_valid=1, instr_out=hold_reg, pc_out=inflight_pc; on redirect load fetch_pc and go to EMPTY; otherwise on stall stay in HOLD; otherwise issue and go to RUN.
REQ-019 Priority SHALL be redirect > stall > issue in every state.
REQ-020 Simultaneous redirect and stall SHALL behave as redirect only.
REQ-021 Latency: with no stall, redirect asserted in cycle c SHALL give instr_valid=0 in cycle c+1 and the target instruction with instr_valid=1 in cycle c+2.
REQ-022 Latency: in steady RUN with no stall, pc_out SHALL advance by 4 every cycle.
REQ-023 Stall SHALL hold instr_out and pc_out bit-stable for as many cycles as it is asserted.
REQ-024 When stall deasserts, the following cycle SHALL present pc_out+4 with no bubble.
REQ-025 No instruction SHALL be duplicated or skipped except for those squashed by redirect.

Reset
REQ-026 While reset is low: state=EMPTY, fetch_pc=RESET_PC, inflight_pc=0, hold_reg=0; outputs instr_valid=0, instr_out=0, pc_out=0, imem_addr=RESET_PC[11:2]; these values SHALL take effect immediately, without a clock edge.
REQ-027 Reset asserted mid-operation, including in HOLD, SHALL discard all in-flight and held data.
REQ-028 The first posedge after reset release SHALL issue RESET_PC.

Structure
REQ-029 Shared package fetch_pkg SHALL hold NUMBER_OF_INSTRUCTIONS=1024, WORD_SIZE=32, the default RESET_PC value, and the fetch_state_t enum {EMPTY, RUN, HOLD}.
REQ-030 The block SHALL be a single module with no sub-module; the memory is instantiated beside it at the level above.

Verification
Bench memory model: word i preloaded with 32'h1000_0000+i; one-cycle read latency.
REQ-031 Reset release -> first cycle instr_valid=0, imem_addr=0; next cycle pc_out=0, instr_out=0x10000000; then pc_out=4, instr_out=0x10000001.
REQ-032 Stall held 3 cycles while pc_out=8 -> instr_out=0x10000002 and pc_out=8 stable for all 3 cycles; next cycle pc_out=12, instr_out=0x10000003.
REQ-033 redirect_pc=0x40 while pc_out=4 -> next cycle instr_valid=0; following cycle pc_out=0x40, instr_out=0x10000010.
REQ-034 Redirect and stall together while in HOLD with redirect_pc=0x47 -> EMPTY for one cycle, then pc_out=0x44, instr_out=0x10000011.
REQ-035 Redirect to 0xFFC -> imem_addr=1023, instr_out=0x100003FF; next pc_out=0x1000 with imem_addr having wrapped to 0, instr_out=0x10000000.
REQ-036 Reset asserted asynchronously mid-stall -> instr_valid, instr_out, pc_out =0 before the next clock edge; after release the sequence of REQ-031 repeats.
